// File: rtl/ssd_pkg.sv
// Shared constants, FSM encoding and small helpers for the seven-segment
// display controller and its sequential binary-to-BCD converter.
package ssd_pkg;

    localparam int VAL_W = 10;
    localparam int DIG_N = 4;
    localparam int BCD_W = 16;

    localparam logic [3:0] BLANK = 4'hF;

    localparam logic [1:0] PAGE_SCORE = 2'd0;
    localparam logic [1:0] PAGE_LINES = 2'd1;
    localparam logic [1:0] PAGE_LEVEL = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } conv_state_e;

    // Double-dabble correction: every nibble of 5 or more gets 3 added
    function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] acc);
        logic [BCD_W-1:0] res;
        res = acc;
        for (int i = 0; i < DIG_N; i++) begin
            if (acc[4*i +: 4] >= 4'd5) begin
                res[4*i +: 4] = acc[4*i +: 4] + 4'd3;
            end else begin
                res[4*i +: 4] = acc[4*i +: 4];
            end
        end
        return res;
    endfunction

    function automatic logic [1:0] page_map(input logic [1:0] sel);
        case (sel)
            2'd1:    return PAGE_LINES;
            2'd2:    return PAGE_LEVEL;
            default: return PAGE_SCORE;
        endcase
    endfunction

    function automatic logic [1:0] page_next(input logic [1:0] cur);
        case (cur)
            PAGE_SCORE: return PAGE_LINES;
            PAGE_LINES: return PAGE_LEVEL;
            default:    return PAGE_SCORE;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 converter: one bit per cycle for VAL_W cycles, then
// a commit cycle in which done is high and bcd holds the finished result.
module bin2bcd_seq
    import ssd_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [VAL_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [BCD_W-1:0] bcd
);

    conv_state_e      state_r;
    conv_state_e      state_nxt_s;
    logic [VAL_W-1:0] shreg_r;
    logic [BCD_W-1:0] acc_r;
    logic [BCD_W-1:0] adj_s;
    logic [3:0]       bit_cnt_r;
    logic             busy_r;
    logic             done_r;
    logic             load_s;
    logic             shift_s;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_SHIFT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (bit_cnt_r == 4'(VAL_W - 1)) begin
                    state_nxt_s = ST_COMMIT;
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            ST_COMMIT: state_nxt_s = ST_IDLE;
            default:   state_nxt_s = ST_IDLE;
        endcase
    end

    // Datapath control decode
    always_comb begin
        load_s  = 1'b0;
        shift_s = 1'b0;
        case (state_r)
            ST_IDLE:  load_s  = start;
            ST_SHIFT: shift_s = 1'b1;
            default: begin
                load_s  = 1'b0;
                shift_s = 1'b0;
            end
        endcase
    end

    assign adj_s = bcd_adjust(acc_r);

    // Shift register, accumulator and registered status flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg_r   <= {VAL_W{1'b0}};
            acc_r     <= {BCD_W{1'b0}};
            bit_cnt_r <= 4'd0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            if (load_s) begin
                shreg_r   <= bin;
                acc_r     <= {BCD_W{1'b0}};
                bit_cnt_r <= 4'd0;
            end else if (shift_s) begin
                {acc_r, shreg_r} <= {adj_s, shreg_r} << 1'b1;
                bit_cnt_r        <= bit_cnt_r + 4'd1;
            end else begin
                shreg_r   <= shreg_r;
                acc_r     <= acc_r;
                bit_cnt_r <= bit_cnt_r;
            end
            busy_r <= (state_nxt_s != ST_IDLE);
            done_r <= (state_nxt_s == ST_COMMIT);
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign bcd  = acc_r;

endmodule

// File: rtl/ssd_display_ctrl.sv
// Four-digit seven-segment sequencer: page selection, change-triggered BCD
// conversion, digit scanning with leading-zero blanking and whole-display blink.
module ssd_display_ctrl
    import ssd_pkg::*;
#(
    parameter int SCAN_W  = 15,
    parameter int DWELL_W = 27,
    parameter int BLINK_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [VAL_W-1:0] score,
    input  logic [VAL_W-1:0] lines,
    input  logic [VAL_W-1:0] level,
    input  logic [1:0]       page_sel,
    input  logic             auto_en,
    input  logic             blink_en,
    output logic [3:0]       ssd_ctl,
    output logic [3:0]       out,
    output logic [1:0]       page,
    output logic             busy
);

    localparam logic [DWELL_W-1:0] DWELL_ONE = {{(DWELL_W-1){1'b0}}, 1'b1};
    localparam logic [SCAN_W-1:0]  SCAN_ONE  = {{(SCAN_W-1){1'b0}}, 1'b1};
    localparam logic [BLINK_W-1:0] BLINK_ONE = {{(BLINK_W-1){1'b0}}, 1'b1};

    logic [1:0]         page_r;
    logic [1:0]         page_nxt_s;
    logic [DWELL_W-1:0] dwell_r;
    logic [SCAN_W-1:0]  scan_cnt_r;
    logic [1:0]         dig_sel_r;
    logic [BLINK_W-1:0] blink_cnt_r;
    logic               blink_phase_r;
    logic [1:0]         last_page_r;
    logic [VAL_W-1:0]   last_val_r;
    logic [VAL_W-1:0]   sel_val_s;
    logic               start_s;
    logic               conv_busy_s;
    logic               conv_done_s;
    logic [BCD_W-1:0]   conv_bcd_s;
    logic [BCD_W-1:0]   bcd_q_r;
    logic [3:0]         digit_s;
    logic               blank_s;
    logic [3:0]         ctl_nxt_s;
    logic [3:0]         out_nxt_s;
    logic [3:0]         ssd_ctl_r;
    logic [3:0]         out_r;

    // Next page: manual follows page_sel, auto advances on dwell wrap
    always_comb begin
        page_nxt_s = page_r;
        if (auto_en) begin
            if (dwell_r == {DWELL_W{1'b1}}) begin
                page_nxt_s = page_next(page_r);
            end else begin
                page_nxt_s = page_r;
            end
        end else begin
            page_nxt_s = page_map(page_sel);
        end
    end

    // Page register and free-running scan, dwell and blink timers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            page_r        <= PAGE_SCORE;
            dwell_r       <= {DWELL_W{1'b0}};
            scan_cnt_r    <= {SCAN_W{1'b0}};
            dig_sel_r     <= 2'd0;
            blink_cnt_r   <= {BLINK_W{1'b0}};
            blink_phase_r <= 1'b0;
        end else begin
            page_r <= page_nxt_s;
            // Held at zero in manual mode so auto rotation always starts a full period
            if (auto_en) begin
                dwell_r <= dwell_r + DWELL_ONE;
            end else begin
                dwell_r <= {DWELL_W{1'b0}};
            end
            scan_cnt_r <= scan_cnt_r + SCAN_ONE;
            if (scan_cnt_r == {SCAN_W{1'b1}}) begin
                dig_sel_r <= dig_sel_r + 2'd1;
            end else begin
                dig_sel_r <= dig_sel_r;
            end
            blink_cnt_r <= blink_cnt_r + BLINK_ONE;
            if (blink_cnt_r == {BLINK_W{1'b1}}) begin
                blink_phase_r <= ~blink_phase_r;
            end else begin
                blink_phase_r <= blink_phase_r;
            end
        end
    end

    // Value shown on the current page
    always_comb begin
        sel_val_s = score;
        case (page_r)
            PAGE_LINES: sel_val_s = lines;
            PAGE_LEVEL: sel_val_s = level;
            default:    sel_val_s = score;
        endcase
    end

    assign start_s = !conv_busy_s && ((page_r != last_page_r) || (sel_val_s != last_val_r));

    // Snapshot of what is being converted; the all-ones value forces a first conversion
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_page_r <= PAGE_SCORE;
            last_val_r  <= {VAL_W{1'b1}};
            bcd_q_r     <= {BCD_W{1'b0}};
        end else begin
            if (start_s) begin
                last_page_r <= page_r;
                last_val_r  <= sel_val_s;
            end else begin
                last_page_r <= last_page_r;
                last_val_r  <= last_val_r;
            end
            if (conv_done_s) begin
                bcd_q_r <= conv_bcd_s;
            end else begin
                bcd_q_r <= bcd_q_r;
            end
        end
    end

    bin2bcd_seq u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (start_s),
        .bin   (sel_val_s),
        .busy  (conv_busy_s),
        .done  (conv_done_s),
        .bcd   (conv_bcd_s)
    );

    // Digit decode with leading-zero blanking and blink override
    always_comb begin
        digit_s = bcd_q_r[4*dig_sel_r +: 4];
        case (dig_sel_r)
            2'd1:    blank_s = (bcd_q_r[BCD_W-1:4]  == 12'd0);
            2'd2:    blank_s = (bcd_q_r[BCD_W-1:8]  == 8'd0);
            2'd3:    blank_s = (bcd_q_r[BCD_W-1:12] == 4'd0);
            default: blank_s = 1'b0;
        endcase
        if (blank_s || (blink_en && blink_phase_r)) begin
            ctl_nxt_s = 4'b1111;
            out_nxt_s = BLANK;
        end else begin
            ctl_nxt_s = ~(4'b0001 << dig_sel_r);
            out_nxt_s = digit_s;
        end
    end

    // Registered display outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ssd_ctl_r <= 4'b1111;
            out_r     <= BLANK;
        end else begin
            ssd_ctl_r <= ctl_nxt_s;
            out_r     <= out_nxt_s;
        end
    end

    assign ssd_ctl = ssd_ctl_r;
    assign out     = out_r;
    assign page    = page_r;
    assign busy    = conv_busy_s;

endmodule

// File: tb/tb_ssd_display_ctrl.sv
// Self-checking bench for ssd_display_ctrl with short scan/dwell/blink periods.
module tb_ssd_display_ctrl;

    localparam int SCAN_W  = 2;
    localparam int DWELL_W = 4;
    localparam int BLINK_W = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] score, lines, level;
    logic [1:0] page_sel;
    logic       auto_en, blink_en;
    logic [3:0] ssd_ctl, out;
    logic [1:0] page;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int k;

    typedef struct {
        logic [1:0] ps;
        logic [9:0] sc;
        logic [9:0] li;
        logic [9:0] le;
        int         expv;
        logic [1:0] expp;
    } vec_t;

    vec_t tab[9];

    ssd_display_ctrl #(.SCAN_W(SCAN_W), .DWELL_W(DWELL_W), .BLINK_W(BLINK_W)) dut (
        .clk(clk), .rst(rst), .score(score), .lines(lines), .level(level),
        .page_sel(page_sel), .auto_en(auto_en), .blink_en(blink_en),
        .ssd_ctl(ssd_ctl), .out(out), .page(page), .busy(busy)
    );

    always #5 clk = ~clk;

    // Clock edges seen since reset release
    always @(posedge clk or negedge rst) begin
        if (!rst) k <= 0;
        else      k <= k + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (k=%0d)", name, act, exp, k);
        end
    endtask

    // Expected display for a stable value v at the current sample point
    task automatic check_disp(input string name, input int v);
        int d, ph, pw;
        logic [3:0] ectl, eout;
        d  = ((k - 1) / (1 << SCAN_W)) % 4;
        ph = ((k - 1) / (1 << BLINK_W)) % 2;
        pw = 1;
        for (int i = 0; i < d; i++) pw = pw * 10;
        if ((blink_en && ph == 1) || (d > 0 && v < pw)) begin
            ectl = 4'b1111;
            eout = 4'hF;
        end else begin
            ectl = 4'b1111 & ~(4'b0001 << d);
            eout = 4'((v / pw) % 10);
        end
        chk({name, "_ctl"}, 32'(ssd_ctl), 32'(ectl));
        chk({name, "_out"}, 32'(out), 32'(eout));
    endtask

    task automatic scan_check(input string name, input int v, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_disp(name, v);
        end
    endtask

    function automatic int model_val(input logic [1:0] ps, input logic [9:0] s,
                                     input logic [9:0] l, input logic [9:0] e);
        int vals[3];
        vals[0] = int'(s); vals[1] = int'(l); vals[2] = int'(e);
        return vals[(ps == 2'd3) ? 0 : int'(ps)];
    endfunction

    task automatic wait_busy(input string name);
        int n;
        n = 0;
        while (!busy && n < 6) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(busy), 32'd1);
    endtask

    initial begin
        int cnt, cur;
        logic [1:0] rps;
        logic [9:0] rs, rl, re;

        score = 10'd0; lines = 10'd0; level = 10'd0;
        page_sel = 2'd0; auto_en = 1'b0; blink_en = 1'b0;
        tab[0] = '{2'd0, 10'd1023, 10'd0,   10'd0,   1023, 2'd0};
        tab[1] = '{2'd0, 10'd57,   10'd0,   10'd0,   57,   2'd0};
        tab[2] = '{2'd0, 10'd100,  10'd0,   10'd0,   100,  2'd0};
        tab[3] = '{2'd1, 10'd100,  10'd12,  10'd3,   12,   2'd1};
        tab[4] = '{2'd2, 10'd100,  10'd12,  10'd3,   3,    2'd2};
        tab[5] = '{2'd3, 10'd808,  10'd12,  10'd3,   808,  2'd0};
        tab[6] = '{2'd0, 10'd0,    10'd12,  10'd3,   0,    2'd0};
        tab[7] = '{2'd2, 10'd0,    10'd12,  10'd999, 999,  2'd2};
        tab[8] = '{2'd1, 10'd0,    10'd10,  10'd999, 10,   2'd1};

        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ctl",  32'(ssd_ctl), 32'hF);
        chk("rst_out",  32'(out),     32'hF);
        chk("rst_page", 32'(page),    32'd0);
        chk("rst_busy", 32'(busy),    32'd0);

        // Sentinel forces a conversion of 0 right after release
        rst = 1'b1;
        cnt = 0;
        repeat (11) begin
            @(negedge clk);
            if (busy) cnt++;
        end
        chk("boot_busy_len", 32'(cnt), 32'd11);
        @(negedge clk);
        chk("boot_busy_end", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        scan_check("boot_disp", 0, 16);

        // Table-driven vectors
        for (int t = 0; t < 9; t++) begin
            page_sel = tab[t].ps; score = tab[t].sc; lines = tab[t].li; level = tab[t].le;
            repeat (30) @(negedge clk);
            chk("tab_page", 32'(page), 32'(tab[t].expp));
            scan_check("tab_disp", tab[t].expv, 16);
        end

        // Busy length of a single conversion
        page_sel = 2'd0; score = 10'd1023;
        wait_busy("lat_start");
        cnt = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!busy) break;
            cnt++;
        end
        chk("lat_busy_len", 32'(cnt), 32'd11);
        repeat (20) @(negedge clk);

        // Value change during the third shift cycle
        score = 10'd42;
        wait_busy("mid_start");
        repeat (2) @(negedge clk);
        score = 10'd43;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!busy) break;
            cnt++;
        end
        chk("mid_rest_len", 32'(cnt), 32'd8);
        @(negedge clk);
        chk("mid_rebusy", 32'(busy), 32'd1);
        repeat (20) @(negedge clk);
        scan_check("mid_disp", 43, 16);

        // Auto rotation
        score = 10'd5; lines = 10'd12; level = 10'd3; page_sel = 2'd0;
        repeat (30) @(negedge clk);
        auto_en = 1'b1;
        cnt = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (page != 2'd0) begin
                cnt = i;
                break;
            end
        end
        chk("auto_first", 32'(cnt), 32'd16);
        chk("auto_page1", 32'(page), 32'd1);
        for (int r = 0; r < 3; r++) begin
            cur = (1 + r) % 3;
            repeat (12) @(negedge clk);
            scan_check("auto_disp", model_val(2'(cur), score, lines, level), 3);
            @(negedge clk);
            chk("auto_next", 32'(page), 32'((cur + 1) % 3));
        end
        auto_en = 1'b0; page_sel = 2'd3;
        @(negedge clk);
        chk("sel3_page", 32'(page), 32'd0);

        // Blink over a fully lit value
        score = 10'd1023;
        repeat (30) @(negedge clk);
        blink_en = 1'b1;
        cnt = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (ssd_ctl == 4'b1111) cnt++;
            check_disp("blink_disp", 1023);
        end
        chk("blink_dark", 32'(cnt), 32'd16);
        blink_en = 1'b0;

        // Reset during a conversion
        score = 10'd77;
        wait_busy("mrst_start");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mrst_ctl",  32'(ssd_ctl), 32'hF);
        chk("mrst_out",  32'(out),     32'hF);
        chk("mrst_page", 32'(page),    32'd0);
        chk("mrst_busy", 32'(busy),    32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_rebusy", 32'(busy), 32'd1);
        repeat (20) @(negedge clk);
        scan_check("mrst_disp", 77, 16);

        // Randomized pages and values against the model
        for (int t = 0; t < 20; t++) begin
            rps = 2'($urandom_range(3, 0));
            rs  = 10'($urandom_range(1023, 0));
            rl  = 10'($urandom_range(1023, 0));
            re  = 10'($urandom_range(1023, 0));
            page_sel = rps; score = rs; lines = rl; level = re;
            repeat (30) @(negedge clk);
            chk("rnd_page", 32'(page), 32'((rps == 2'd3) ? 0 : int'(rps)));
            scan_check("rnd_disp", model_val(rps, rs, rl, re), 8);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
